// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath definitions.
//   DATA_W       - ALU result width
//   RD_W         - destination register index width
//   alu_result_t - packed ALU result entry {y, zero, rd}
package cpu_pkg;

    localparam int DATA_W = 19;
    localparam int RD_W   = 3;

    typedef struct packed {
        logic [DATA_W-1:0] y;
        logic              zero;
        logic [RD_W-1:0]   rd;
    } alu_result_t;

endpackage

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FIFO between the ALU and the writeback stage.
// Every entry holds the ALU result, its zero flag and the destination
// register index. There is no bypass: an entry pushed on one edge shows
// up on out_* in the next cycle at the earliest.
//
// Ports
//   clk, rst                   single clock, synchronous active-high reset
//   in_valid/in_ready          push handshake (in_ready = not full)
//   in_y, in_zero, in_rd       entry to push
//   out_valid/out_ready        pop handshake (out_valid = not empty)
//   out_y, out_zero, out_rd    head entry
//   flush                      drop every buffered entry
//   count                      current occupancy
//   flag_z                     zero flag of the most recently popped entry
//
// DEPTH must be a power of two and at least 2. The pointers then wrap
// naturally, because they are exactly clog2(DEPTH) bits wide.
module alu_result_buffer #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RD_W   = cpu_pkg::RD_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_y,
    input  logic                       in_zero,
    input  logic [RD_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_y,
    output logic                       out_zero,
    output logic [RD_W-1:0]            out_rd,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       flag_z
);

    import cpu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    // This mirrors alu_result_t, but it is sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] y;
        logic              zero;
        logic [RD_W-1:0]   rd;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     cnt;
    logic               push;
    logic               pop;
    entry_t             head;

    // in_ready depends only on occupancy. A full buffer therefore
    // refuses a push even when a pop happens in the same cycle.
    assign in_ready  = (cnt != DEPTH[PTR_W:0]);
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head      = mem[rd_ptr];
    assign out_y     = head.y;
    assign out_zero  = head.zero;
    assign out_rd    = head.rd;
    assign count     = cnt;

    // The storage has no reset. Writes are suppressed under rst/flush so
    // that a dropped push leaves no trace, although slots past the
    // occupancy are don't-care anyway.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= '{y: in_y, zero: in_zero, rd: in_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            flag_z <= 1'b0;
        end else if (flush) begin
            // flag_z deliberately survives a flush.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                flag_z <= head.zero;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

    localparam int DATA_W = cpu_pkg::DATA_W;
    localparam int RD_W   = cpu_pkg::RD_W;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct {
        logic [DATA_W-1:0] y;
        logic              zero;
        logic [RD_W-1:0]   rd;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_y = '0;
    logic              in_zero = 1'b0;
    logic [RD_W-1:0]   in_rd = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_y;
    logic              out_zero;
    logic [RD_W-1:0]   out_rd;
    logic              flush = 1'b0;
    logic [CW-1:0]     count;
    logic              flag_z;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of entries plus the last popped zero flag.
    ent_t q[$];
    logic mflag = 1'b0;

    always #5 clk = ~clk;

    alu_result_buffer #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_zero(in_zero), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_zero(out_zero), .out_rd(out_rd), .flush(flush),
        .count(count), .flag_z(flag_z)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check every visible output against the model.
    task automatic chk_all();
        chk("count", 64'(count), 64'(q.size()));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        chk("flag_z", 64'(flag_z), 64'(mflag));
        if (q.size() != 0) begin
            chk("out_y", 64'(out_y), 64'(q[0].y));
            chk("out_zero", 64'(out_zero), 64'(q[0].zero));
            chk("out_rd", 64'(out_rd), 64'(q[0].rd));
        end
    endtask

    // Run one clock with the inputs as currently driven, update the model
    // from the behavioural rules, and check the outputs 1 time unit after the edge.
    task automatic cyc();
        bit do_push, do_pop;
        ent_t e;
        do_push = in_valid && (q.size() != DEPTH);
        do_pop  = out_ready && (q.size() != 0);
        e.y = in_y; e.zero = in_zero; e.rd = in_rd;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            mflag = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (do_pop) begin
                mflag = q[0].zero;
                void'(q.pop_front());
            end
            if (do_push) q.push_back(e);
        end
        chk_all();
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] y, input bit z,
                         input logic [RD_W-1:0] rd, input bit ordy);
        in_valid = v; in_y = y; in_zero = z; in_rd = rd; out_ready = ordy;
    endtask

    task automatic do_reset();
        rst = 1'b1; drive(0, '0, 0, '0, 0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flag_z", 64'(flag_z), 64'd0);

        // Two pushes with the consumer stalled
        drive(1, 19'h00005, 0, 3'd1, 0); cyc();
        drive(1, 19'h7FFFF, 0, 3'd2, 0); cyc();
        chk("two_count", 64'(count), 64'd2);
        chk("two_out_y", 64'(out_y), 64'h5);
        chk("two_in_ready", 64'(in_ready), 64'd1);

        // Fill up; a fifth push is refused
        drive(1, 19'h00123, 1, 3'd3, 0); cyc();
        drive(1, 19'h00456, 0, 3'd4, 0); cyc();
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(1, 19'h00789, 0, 3'd5, 0); cyc();
        chk("full_hold_count", 64'(count), 64'd4);
        chk("full_hold_y", 64'(out_y), 64'h5);

        // Full, with pop and push together: only the pop happens
        drive(1, 19'h00ABC, 1, 3'd6, 1); cyc();
        chk("fullpp_count", 64'(count), 64'd3);
        chk("fullpp_y", 64'(out_y), 64'h7FFFF);
        drive(1, 19'h00ABC, 1, 3'd6, 0); cyc();
        chk("fullpp_next_count", 64'(count), 64'd4);

        // Flush with three entries and a concurrent push
        drive(0, '0, 0, '0, 1); cyc();
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1; drive(1, 19'h11111, 1, 3'd7, 0); cyc();
        flush = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);

        // zero flag tracking
        do_reset();
        drive(1, 19'h0, 1, 3'd1, 0); cyc();
        drive(1, 19'h1, 0, 3'd2, 0); cyc();
        drive(0, '0, 0, '0, 1); cyc();
        chk("flag_after_z1", 64'(flag_z), 64'd1);
        cyc();
        chk("flag_after_z0", 64'(flag_z), 64'd0);
        drive(0, '0, 0, '0, 0);
        repeat (3) cyc();
        chk("flag_idle", 64'(flag_z), 64'd0);

        // Ten entries with out_ready toggling every cycle, across pointer wrap
        begin
            int sent = 0;
            int guard = 0;
            bit ordy = 1'b0;
            while ((sent < 10 || q.size() != 0) && guard < 200) begin
                bit acc;
                acc = (sent < 10) && (q.size() != DEPTH);
                drive(sent < 10, DATA_W'(32'h100 + sent), sent[0], RD_W'(sent), ordy);
                cyc();
                if (acc) sent++;
                ordy = ~ordy;
                guard++;
            end
            chk("wrap_drained", 64'(guard < 200), 64'd1);
        end

        // Reset mid-stream
        drive(1, 19'h1, 1, 3'd1, 0); cyc();
        drive(1, 19'h2, 1, 3'd2, 0); cyc();
        drive(0, '0, 0, '0, 1); cyc();
        rst = 1'b1; drive(1, 19'h3, 0, 3'd3, 1); cyc();
        rst = 1'b0;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_flag_z", 64'(flag_z), 64'd0);

        // Random traffic
        drive(0, '0, 0, '0, 0);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), DATA_W'($urandom), $urandom_range(0, 1),
                  RD_W'($urandom), $urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            cyc();
        end
        flush = 1'b0; rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 19, meaning the ALU result width.
REQ-002 The block SHALL have parameter RD_W, default 3, meaning the destination register index width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; it must be a power of two, at least 2.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port in_valid: input, 1 bit, the ALU result presented this cycle is valid.
REQ-008 Port in_ready: output, 1 bit, the buffer can accept an entry this cycle.
REQ-009 Port in_y: input, DATA_W bits, the ALU result.
REQ-010 Port in_zero: input, 1 bit, the ALU zero flag for in_y.
REQ-011 Port in_rd: input, RD_W bits, the destination register index.
REQ-012 Port out_valid: output, 1 bit, the head entry is valid.
REQ-013 Port out_ready: input, 1 bit, the writeback stage consumes the head entry.
REQ-014 Port out_y / out_zero / out_rd: outputs, DATA_W / 1 / RD_W bits, the head entry fields.
REQ-015 Port flush: input, 1 bit, discard all buffered entries.
REQ-016 Port count: output, clog2(DEPTH)+1 bits, the current occupancy.
REQ-017 Port flag_z: output, 1 bit, the zero flag of the most recently popped entry.

Function
REQ-018 A push SHALL occur on a cycle where in_valid && in_ready; a pop SHALL occur on a cycle where out_valid && out_ready.
REQ-019 in_ready SHALL equal (count != DEPTH), with no dependence on out_ready; a full buffer refuses a push even when a pop happens in the same cycle.
REQ-020 out_valid SHALL equal (count != 0); out_y/out_zero/out_rd SHALL be driven from the storage entry at the read pointer.
REQ-021 Latency: an entry pushed at edge N SHALL appear on out_* at cycle N+1; there is no same-cycle bypass from in_* to out_*.
REQ-022 Order SHALL be strict FIFO; write and read pointers SHALL wrap modulo DEPTH.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH: count SHALL be unchanged and both pointers SHALL advance.
REQ-024 Push only: count SHALL increment by 1. Pop only: count SHALL decrement by 1.
REQ-025 out_* SHALL hold stable while out_valid && !out_ready.
REQ-026 On a pop, flag_z SHALL load out_zero at that edge; otherwise it SHALL hold its value.
REQ-027 flush SHALL take priority over push and pop; the next cycle SHALL have count=0 and both pointers at 0; a concurrent push is dropped; flag_z SHALL be unchanged.
REQ-028 Storage contents SHALL need no reset; out_* values while out_valid=0 are don't-care.

Reset
REQ-029 rst SHALL take priority over flush, push and pop.
REQ-030 The cycle after rst, the block SHALL have count=0, pointers 0, out_valid=0, in_ready=1 and flag_z=0.
REQ-031 rst asserted mid-stream SHALL discard all entries, with no pop or flag_z update on that edge.

Structure
REQ-032 DATA_W=19, RD_W=3 and a packed result-entry type {y, zero, rd} SHALL live in the shared package cpu_pkg, and the block SHALL import it.
REQ-033 The block SHALL be a single module with an inline storage array and pointer/count registers; no sub-module is needed.

Verification
REQ-034 Reset, then push y=0x00005/rd=1 and y=0x7FFFF/rd=2 with out_ready=0: count=2, out_y=0x00005, in_ready=1.
REQ-035 Push 4 entries with out_ready=0: count=4, in_ready=0; a 5th in_valid is not accepted and count stays 4.
REQ-036 Full buffer, out_ready=1 and in_valid=1 together: a pop only, count=3; the next cycle the push is accepted and count=4.
REQ-037 Run 10 entries with out_ready toggling every cycle: outputs appear in push order across pointer wrap, with no loss or duplication.
REQ-038 Pop an entry with zero=1, then one with zero=0: flag_z=1, then flag_z=0; flag_z holds while idle.
REQ-039 flush with count=3 and in_valid=1: count=0 and out_valid=0 the next cycle; rst mid-stream gives the reset values of REQ-030.
